// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the LEGv8 datapath, feeding the
// forwarding unit, with stall/flush/bubble handling and a retired counter.
module ex_mem_wb_pipe #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic              ex_MemToReg,
  input  logic [REG_W-1:0]  ex_Rd,
  input  logic [DATA_W-1:0] ex_ALUResult,
  input  logic [DATA_W-1:0] ex_StoreData,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              ExMem_valid,
  output logic              ExMem_RegWrite,
  output logic              ExMem_MemRead,
  output logic              ExMem_MemWrite,
  output logic              ExMem_MemToReg,
  output logic [REG_W-1:0]  ExMem_Rd,
  output logic [DATA_W-1:0] ExMem_ALUResult,
  output logic [DATA_W-1:0] ExMem_StoreData,
  output logic              MemWB_valid,
  output logic              MemWB_RegWrite,
  output logic [REG_W-1:0]  MemWB_Rd,
  output logic [DATA_W-1:0] MemWB_WriteData,
  output logic [CNT_W-1:0]  retired_count
);

  // Bubbles carry X31 so the forwarding unit can never match them.
  localparam logic [REG_W-1:0] NULL_RD = {REG_W{1'b1}};

  logic              exmem_valid_q,    exmem_valid_d;
  logic              exmem_regwrite_q, exmem_regwrite_d;
  logic              exmem_memread_q,  exmem_memread_d;
  logic              exmem_memwrite_q, exmem_memwrite_d;
  logic              exmem_memtoreg_q, exmem_memtoreg_d;
  logic [REG_W-1:0]  exmem_rd_q,       exmem_rd_d;
  logic [DATA_W-1:0] exmem_alu_q,      exmem_alu_d;
  logic [DATA_W-1:0] exmem_store_q,    exmem_store_d;

  logic              memwb_valid_q,    memwb_valid_d;
  logic              memwb_regwrite_q, memwb_regwrite_d;
  logic [REG_W-1:0]  memwb_rd_q,       memwb_rd_d;
  logic [DATA_W-1:0] memwb_wdata_q,    memwb_wdata_d;

  logic [CNT_W-1:0]  retired_q,        retired_d;

  logic              ex_capture;
  logic [DATA_W-1:0] wb_data;

  assign ex_capture = ex_valid & ~flush;
  assign wb_data    = exmem_memtoreg_q ? mem_ReadData : exmem_alu_q;

  always_comb begin
    exmem_valid_d    = exmem_valid_q;
    exmem_regwrite_d = exmem_regwrite_q;
    exmem_memread_d  = exmem_memread_q;
    exmem_memwrite_d = exmem_memwrite_q;
    exmem_memtoreg_d = exmem_memtoreg_q;
    exmem_rd_d       = exmem_rd_q;
    exmem_alu_d      = exmem_alu_q;
    exmem_store_d    = exmem_store_q;
    if (!stall) begin
      exmem_valid_d    = ex_capture;
      exmem_regwrite_d = ex_capture & ex_RegWrite;
      exmem_memread_d  = ex_capture & ex_MemRead;
      exmem_memwrite_d = ex_capture & ex_MemWrite;
      exmem_memtoreg_d = ex_capture & ex_MemToReg;
      exmem_rd_d       = ex_capture ? ex_Rd        : NULL_RD;
      exmem_alu_d      = ex_capture ? ex_ALUResult : '0;
      exmem_store_d    = ex_capture ? ex_StoreData : '0;
    end
  end

  // Bubble data is zeroed so an undriven read bus never leaks X downstream.
  always_comb begin
    memwb_valid_d    = memwb_valid_q;
    memwb_regwrite_d = memwb_regwrite_q;
    memwb_rd_d       = memwb_rd_q;
    memwb_wdata_d    = memwb_wdata_q;
    retired_d        = retired_q;
    if (!stall) begin
      memwb_valid_d    = exmem_valid_q;
      memwb_regwrite_d = exmem_valid_q & exmem_regwrite_q;
      memwb_rd_d       = exmem_valid_q ? exmem_rd_q : NULL_RD;
      memwb_wdata_d    = exmem_valid_q ? wb_data    : '0;
      if (memwb_valid_q) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_valid_q    <= 1'b0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_rd_q       <= NULL_RD;
      exmem_alu_q      <= '0;
      exmem_store_q    <= '0;
      memwb_valid_q    <= 1'b0;
      memwb_regwrite_q <= 1'b0;
      memwb_rd_q       <= NULL_RD;
      memwb_wdata_q    <= '0;
      retired_q        <= '0;
    end else begin
      exmem_valid_q    <= exmem_valid_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memwrite_q <= exmem_memwrite_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_alu_q      <= exmem_alu_d;
      exmem_store_q    <= exmem_store_d;
      memwb_valid_q    <= memwb_valid_d;
      memwb_regwrite_q <= memwb_regwrite_d;
      memwb_rd_q       <= memwb_rd_d;
      memwb_wdata_q    <= memwb_wdata_d;
      retired_q        <= retired_d;
    end
  end

  assign ExMem_valid     = exmem_valid_q;
  assign ExMem_RegWrite  = exmem_valid_q & exmem_regwrite_q;
  assign ExMem_MemRead   = exmem_valid_q & exmem_memread_q;
  assign ExMem_MemWrite  = exmem_valid_q & exmem_memwrite_q;
  assign ExMem_MemToReg  = exmem_memtoreg_q;
  assign ExMem_Rd        = exmem_rd_q;
  assign ExMem_ALUResult = exmem_alu_q;
  assign ExMem_StoreData = exmem_store_q;
  assign MemWB_valid     = memwb_valid_q;
  assign MemWB_RegWrite  = memwb_valid_q & memwb_regwrite_q;
  assign MemWB_Rd        = memwb_rd_q;
  assign MemWB_WriteData = memwb_wdata_q;
  assign retired_count   = retired_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: queue-based pipeline model plus
// a vector table and hand sequences for stall, flush, reset and wrap.
module tb_ex_mem_wb_pipe;

  localparam logic [4:0] NULL_RD = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
  logic [4:0]  ex_Rd;
  logic [63:0] ex_ALUResult, ex_StoreData, mem_ReadData;

  logic        ExMem_valid, ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg;
  logic [4:0]  ExMem_Rd;
  logic [63:0] ExMem_ALUResult, ExMem_StoreData;
  logic        MemWB_valid, MemWB_RegWrite;
  logic [4:0]  MemWB_Rd;
  logic [63:0] MemWB_WriteData;
  logic [31:0] retired_count;

  logic        w_em_valid, w_em_rw, w_em_mr, w_em_mw, w_em_m2r;
  logic [4:0]  w_em_rd;
  logic [63:0] w_em_alu, w_em_store;
  logic        w_mw_valid, w_mw_rw;
  logic [4:0]  w_mw_rd;
  logic [63:0] w_mw_wdata;
  logic [3:0]  w_retired_count;

  always #5 clk = ~clk;

  ex_mem_wb_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_Rd(ex_Rd),
    .ex_ALUResult(ex_ALUResult), .ex_StoreData(ex_StoreData), .mem_ReadData(mem_ReadData),
    .ExMem_valid(ExMem_valid), .ExMem_RegWrite(ExMem_RegWrite), .ExMem_MemRead(ExMem_MemRead),
    .ExMem_MemWrite(ExMem_MemWrite), .ExMem_MemToReg(ExMem_MemToReg), .ExMem_Rd(ExMem_Rd),
    .ExMem_ALUResult(ExMem_ALUResult), .ExMem_StoreData(ExMem_StoreData),
    .MemWB_valid(MemWB_valid), .MemWB_RegWrite(MemWB_RegWrite), .MemWB_Rd(MemWB_Rd),
    .MemWB_WriteData(MemWB_WriteData), .retired_count(retired_count)
  );

  // Narrow-counter copy driven by the same stimulus, used for the wrap check.
  ex_mem_wb_pipe #(.DATA_W(64), .REG_W(5), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_Rd(ex_Rd),
    .ex_ALUResult(ex_ALUResult), .ex_StoreData(ex_StoreData), .mem_ReadData(mem_ReadData),
    .ExMem_valid(w_em_valid), .ExMem_RegWrite(w_em_rw), .ExMem_MemRead(w_em_mr),
    .ExMem_MemWrite(w_em_mw), .ExMem_MemToReg(w_em_m2r), .ExMem_Rd(w_em_rd),
    .ExMem_ALUResult(w_em_alu), .ExMem_StoreData(w_em_store),
    .MemWB_valid(w_mw_valid), .MemWB_RegWrite(w_mw_rw), .MemWB_Rd(w_mw_rd),
    .MemWB_WriteData(w_mw_wdata), .retired_count(w_retired_count)
  );

  typedef struct {
    logic        valid, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  rd;
    logic [63:0] alu, store, wdata;
  } entry_t;

  typedef struct {
    logic        stall, flush, valid, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  rd;
    logic [63:0] alu, store, rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        exp_mw_valid;
    logic [4:0]  exp_mw_rd;
    logic [63:0] exp_mw_wd;
    int unsigned exp_cnt;
  } vec_t;

  entry_t      pipe_q[$];
  int unsigned model_cnt;
  int          compared   = 0;
  int          mismatched = 0;
  vec_t        table_v[9];

  function automatic stim_t mk(input logic st, input logic fl, input logic v, input logic rw,
                               input logic mr, input logic mw, input logic m2r,
                               input logic [4:0] rd, input logic [63:0] alu,
                               input logic [63:0] store, input logic [63:0] rdata);
    stim_t s;
    s.stall = st; s.flush = fl; s.valid = v; s.regwrite = rw; s.memread = mr;
    s.memwrite = mw; s.memtoreg = m2r; s.rd = rd; s.alu = alu; s.store = store;
    s.rdata = rdata;
    return s;
  endfunction

  function automatic entry_t bubble();
    entry_t e;
    e.valid = 1'b0; e.regwrite = 1'b0; e.memread = 1'b0; e.memwrite = 1'b0;
    e.memtoreg = 1'b0; e.rd = NULL_RD; e.alu = '0; e.store = '0; e.wdata = '0;
    return e;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    pipe_q.push_back(bubble());
    pipe_q.push_back(bubble());
    model_cnt = 0;
  endtask

  // pipe_q[0] is MEM/WB, pipe_q[1] is EX/MEM; each non-stalled edge shifts by one.
  task automatic model_edge(input stim_t s);
    entry_t e, m;
    if (!s.stall) begin
      m = pipe_q[1];
      if (m.valid) m.wdata = m.memtoreg ? s.rdata : m.alu;
      pipe_q[1] = m;
      if (pipe_q[0].valid) model_cnt++;
      e = bubble();
      if (s.valid && !s.flush) begin
        e.valid = 1'b1; e.regwrite = s.regwrite; e.memread = s.memread;
        e.memwrite = s.memwrite; e.memtoreg = s.memtoreg; e.rd = s.rd;
        e.alu = s.alu; e.store = s.store;
      end
      pipe_q.push_back(e);
      void'(pipe_q.pop_front());
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    entry_t em, mw;
    em = pipe_q[1];
    mw = pipe_q[0];
    check("ExMem_valid",    64'(ExMem_valid),    64'(em.valid));
    check("ExMem_RegWrite", 64'(ExMem_RegWrite), 64'(em.regwrite));
    check("ExMem_MemRead",  64'(ExMem_MemRead),  64'(em.memread));
    check("ExMem_MemWrite", 64'(ExMem_MemWrite), 64'(em.memwrite));
    check("ExMem_Rd",       64'(ExMem_Rd),       64'(em.rd));
    if (em.valid) begin
      check("ExMem_MemToReg",  64'(ExMem_MemToReg), 64'(em.memtoreg));
      check("ExMem_ALUResult", ExMem_ALUResult,     em.alu);
      check("ExMem_StoreData", ExMem_StoreData,     em.store);
    end
    check("MemWB_valid",    64'(MemWB_valid),    64'(mw.valid));
    check("MemWB_RegWrite", 64'(MemWB_RegWrite), 64'(mw.regwrite));
    check("MemWB_Rd",       64'(MemWB_Rd),       64'(mw.rd));
    if (mw.valid) check("MemWB_WriteData", MemWB_WriteData, mw.wdata);
    check("retired_count",   64'(retired_count),   64'(model_cnt));
    check("retired_count_4", 64'(w_retired_count), 64'(model_cnt[3:0]));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare.
  task automatic apply_stimulus(input stim_t s);
    stall = s.stall; flush = s.flush; ex_valid = s.valid; ex_RegWrite = s.regwrite;
    ex_MemRead = s.memread; ex_MemWrite = s.memwrite; ex_MemToReg = s.memtoreg;
    ex_Rd = s.rd; ex_ALUResult = s.alu; ex_StoreData = s.store; mem_ReadData = s.rdata;
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
    check_output();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    table_v[0] = '{mk(0,0,1,1,0,0,0, 1, 64'h5,   64'h0,    64'h0),    1'b0, 5'd31, 64'h0,    0};
    table_v[1] = '{mk(0,0,1,1,0,0,0, 2, 64'h7,   64'h0,    64'h111),  1'b1, 5'd1,  64'h5,    0};
    table_v[2] = '{mk(0,0,1,1,1,0,1, 9, 64'h100, 64'h0,    64'h222),  1'b1, 5'd2,  64'h7,    1};
    table_v[3] = '{mk(0,0,1,0,0,1,0, 0, 64'h108, 64'hBEEF, 64'hDEAD), 1'b1, 5'd9,  64'hDEAD, 2};
    table_v[4] = '{mk(0,0,1,1,0,0,1,12, 64'h55,  64'h0,    64'h333),  1'b1, 5'd0,  64'h108,  3};
    table_v[5] = '{mk(0,1,1,1,0,0,0, 4, 64'h44,  64'h0,    64'h777),  1'b1, 5'd12, 64'h777,  4};
    table_v[6] = '{mk(0,0,1,1,0,0,0, 3, 64'h9,   64'h0,    64'h888),  1'b0, 5'd31, 64'h0,    5};
    table_v[7] = '{mk(0,0,0,1,0,0,0, 6, 64'h66,  64'h0,    64'h999),  1'b1, 5'd3,  64'h9,    5};
    table_v[8] = '{mk(0,0,0,0,0,0,0, 0, 64'h0,   64'h0,    64'h0),    1'b0, 5'd31, 64'h0,    6};

    reset = 1'b1;
    stall = 0; flush = 0; ex_valid = 0; ex_RegWrite = 0; ex_MemRead = 0; ex_MemWrite = 0;
    ex_MemToReg = 0; ex_Rd = 0; ex_ALUResult = 0; ex_StoreData = 0; mem_ReadData = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_output();
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(table_v[i].s);
      check($sformatf("vec%0d_mw_valid", i), 64'(MemWB_valid), 64'(table_v[i].exp_mw_valid));
      check($sformatf("vec%0d_mw_rd", i),    64'(MemWB_Rd),    64'(table_v[i].exp_mw_rd));
      if (table_v[i].exp_mw_valid)
        check($sformatf("vec%0d_mw_wd", i), MemWB_WriteData, table_v[i].exp_mw_wd);
      check($sformatf("vec%0d_cnt", i), 64'(retired_count), 64'(table_v[i].exp_cnt));
    end

    // Two loads in flight, then a 3-cycle stall with a changing read bus and a flush pulse.
    apply_stimulus(mk(0,0,1,1,1,0,1,10, 64'h200, 64'h0, 64'h0));
    apply_stimulus(mk(0,0,1,1,1,0,1,11, 64'h300, 64'h0, 64'hA0A0));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(mk(1, (i == 1), 1,1,0,0,0, 13, 64'h999, 64'h0, 64'h1111 * (i + 1)));
      check("stall_em_rd",  64'(ExMem_Rd),      64'd11);
      check("stall_em_alu", ExMem_ALUResult,    64'h300);
      check("stall_em_mr",  64'(ExMem_MemRead), 64'd1);
      check("stall_mw_rd",  64'(MemWB_Rd),      64'd10);
      check("stall_mw_wd",  MemWB_WriteData,    64'hA0A0);
      check("stall_cnt",    64'(retired_count), 64'd6);
    end
    apply_stimulus(mk(0,0,1,1,0,0,0,15, 64'h500, 64'h0, 64'hB0B0));
    check("unstall_mw_rd", 64'(MemWB_Rd),      64'd11);
    check("unstall_mw_wd", MemWB_WriteData,    64'hB0B0);
    check("unstall_cnt",   64'(retired_count), 64'd7);

    // Asynchronous reset with valid instructions in both stages.
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    check("rst_em_rd", 64'(ExMem_Rd),      64'd31);
    check("rst_mw_rd", 64'(MemWB_Rd),      64'd31);
    check("rst_cnt",   64'(retired_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(mk(0,0,1,1,0,0,0, 5, 64'h5, 64'h0, 64'h0));
    check("post_rst_mw_valid1", 64'(MemWB_valid), 64'd0);
    apply_stimulus(idle);
    check("post_rst_mw_valid2", 64'(MemWB_valid), 64'd1);
    check("post_rst_mw_rd",     64'(MemWB_Rd),    64'd5);

    // Enough retirements to wrap the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(mk(0,0,1,1,0,0,0, 5'(i % 31), 64'(i), 64'h0, 64'h0));
      if (model_cnt == 16) check("cnt_wrap_4bit", 64'(w_retired_count), 64'd0);
    end
    apply_stimulus(idle);
    apply_stimulus(idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
